// File: rtl/switch_debouncer.sv
// Switch debouncer: two-flop synchronizer per line followed by a per-bit
// stability counter. A new level is accepted only after it has been seen
// on the synchronized input for STABLE_CYCLES consecutive cycles.
// Outputs are fully registered; sw_changed pulses in the cycle sw updates.
// Optional macro SW_DEBOUNCE_EDGE_EN adds per-bit sw_rise / sw_fall pulses.
module switch_debouncer #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw,
   output logic             sw_changed
`ifdef SW_DEBOUNCE_EDGE_EN
   ,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall
`endif
);

   localparam int            CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] TC = CW'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [CW-1:0]    cnt     [WIDTH];
   logic [CW-1:0]    cnt_nxt [WIDTH];
   logic [WIDTH-1:0] sw_nxt;

   // Bring the raw pins into clk; no logic between the two stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw_raw;
         s2 <= s1;
      end
   end

   // Per-bit stability count: any matching sample restarts it, terminal count accepts the new level.
   always_comb begin
      sw_nxt = sw;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (s2[i] != sw[i]) begin
            if (cnt[i] == TC) begin
               sw_nxt[i] = s2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

   // Register counters, debounced level and the change strobe together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
         sw         <= '0;
         sw_changed <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
         sw         <= sw_nxt;
         sw_changed <= |(sw_nxt ^ sw);
      end
   end

`ifdef SW_DEBOUNCE_EDGE_EN
   // Per-bit edge pulses, coincident with sw_changed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_rise <= '0;
         sw_fall <= '0;
      end else begin
         sw_rise <= sw_nxt & ~sw;
         sw_fall <= ~sw_nxt & sw;
      end
   end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (WIDTH=4, STABLE_CYCLES=4).
// Expected updates (cycle, value, edge pulses) are queued when stimulus is
// driven and compared when the DUT raises sw_changed.
module tb_switch_debouncer;

   localparam int W  = 4;
   localparam int SC = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] sw_raw = 4'hF;
   logic [W-1:0] sw;
   logic         sw_changed;
`ifdef SW_DEBOUNCE_EDGE_EN
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
`endif

   switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
      .clk        (clk),
      .rst        (rst),
      .sw_raw     (sw_raw),
      .sw         (sw),
      .sw_changed (sw_changed)
`ifdef SW_DEBOUNCE_EDGE_EN
      ,
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           cyc;
      logic [W-1:0] val;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
   } exp_t;

   exp_t         sbq[$];
   logic [W-1:0] exp_sw = '0;
   int           checks = 0;
   int           errors = 0;

   // Queue an expected update; inputs are driven at a negedge, so the
   // update appears SC+2 edges later, i.e. at cycle count now + SC + 2.
   function automatic void push_exp(input int at, input logic [W-1:0] v);
      exp_t e;
      e.cyc  = at;
      e.val  = v;
      e.rise = v & ~exp_sw;
      e.fall = ~v & exp_sw;
      exp_sw = v;
      sbq.push_back(e);
   endfunction

   task automatic test_reset();
      exp_t e;
      int   c0;
      rst = 1'b1; sw_raw = 4'hF;
      repeat (3) @(negedge clk);
      checks++;
      if (sw !== 4'h0 || sw_changed !== 1'b0) begin
         errors++;
         $display("FAIL reset_state sw=%h chg=%b required sw=0 chg=0", sw, sw_changed);
      end
      rst = 1'b0;
      c0 = cyc;
      push_exp(c0 + SC + 2, 4'hF);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (sw_changed) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL reset_release_extra_pulse cyc=%0d sw=%h required no pulse", cyc, sw);
            end else begin
               e = sbq.pop_front();
               if (cyc !== e.cyc || sw !== e.val) begin
                  errors++;
                  $display("FAIL reset_release_update cyc=%0d sw=%h required cyc=%0d sw=%h", cyc, sw, e.cyc, e.val);
               end
            end
         end
      end
      checks++;
      if (sbq.size() != 0 || sw !== 4'hF) begin
         errors++;
         $display("FAIL reset_release_final pending=%0d sw=%h required pending=0 sw=f", sbq.size(), sw);
         sbq.delete();
      end
   endtask

   task automatic test_reset_mid_count();
      sw_raw = 4'h0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      exp_sw = 4'h0;
      #1;
      checks++;
      if (sw !== 4'h0 || sw_changed !== 1'b0) begin
         errors++;
         $display("FAIL reset_async_clear sw=%h chg=%b required sw=0 chg=0", sw, sw_changed);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++;
         if (sw !== 4'h0 || sw_changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after cyc=%0d sw=%h chg=%b required sw=0 chg=0", cyc, sw, sw_changed);
         end
      end
   endtask

   task automatic test_glitch();
      sw_raw = 4'b0100;
      repeat (SC - 1) @(negedge clk);
      sw_raw = 4'h0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++;
         if (sw !== 4'h0 || sw_changed !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject cyc=%0d sw=%h chg=%b required sw=0 chg=0", cyc, sw, sw_changed);
         end
      end
   endtask

   task automatic test_bounce();
      exp_t e;
      sw_raw = 4'h0;
      for (int j = 0; j < 10; j++) begin
         sw_raw[0] = ~sw_raw[0];
         repeat (2) begin
            @(negedge clk);
            checks++;
            if (sw !== 4'h0 || sw_changed !== 1'b0) begin
               errors++;
               $display("FAIL bounce_hold cyc=%0d sw=%h chg=%b required sw=0 chg=0", cyc, sw, sw_changed);
            end
         end
      end
      sw_raw[0] = 1'b1;
      push_exp(cyc + SC + 2, 4'h1);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (sw_changed) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL bounce_extra_pulse cyc=%0d sw=%h required no pulse", cyc, sw);
            end else begin
               e = sbq.pop_front();
               if (cyc !== e.cyc || sw !== e.val) begin
                  errors++;
                  $display("FAIL bounce_settle cyc=%0d sw=%h required cyc=%0d sw=%h", cyc, sw, e.cyc, e.val);
               end
            end
         end
      end
      checks++;
      if (sbq.size() != 0 || sw !== 4'h1) begin
         errors++;
         $display("FAIL bounce_final pending=%0d sw=%h required pending=0 sw=1", sbq.size(), sw);
         sbq.delete();
      end
   endtask

   task automatic test_simultaneous();
      exp_t         e;
      logic [W-1:0] pat [2];
      pat[0] = 4'h0;
      pat[1] = 4'hD;
      for (int p = 0; p < 2; p++) begin
         sw_raw = pat[p];
         push_exp(cyc + SC + 2, pat[p]);
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (sw_changed) begin
               checks++;
               if (sbq.size() == 0) begin
                  errors++;
                  $display("FAIL simul_extra_pulse cyc=%0d sw=%h required no pulse", cyc, sw);
               end else begin
                  e = sbq.pop_front();
                  if (cyc !== e.cyc || sw !== e.val) begin
                     errors++;
                     $display("FAIL simul_update cyc=%0d sw=%h required cyc=%0d sw=%h", cyc, sw, e.cyc, e.val);
                  end
               end
            end
         end
         checks++;
         if (sbq.size() != 0 || sw !== pat[p]) begin
            errors++;
            $display("FAIL simul_final pending=%0d sw=%h required pending=0 sw=%h", sbq.size(), sw, pat[p]);
            sbq.delete();
         end
      end
   endtask

`ifdef SW_DEBOUNCE_EDGE_EN
   task automatic test_edges();
      exp_t         e;
      logic [W-1:0] pat [2];
      pat[0] = 4'hF;
      pat[1] = 4'hD;
      for (int p = 0; p < 2; p++) begin
         sw_raw = pat[p];
         push_exp(cyc + SC + 2, pat[p]);
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (sw_changed) begin
               checks++;
               if (sbq.size() == 0) begin
                  errors++;
                  $display("FAIL edge_extra_pulse cyc=%0d sw=%h required no pulse", cyc, sw);
               end else begin
                  e = sbq.pop_front();
                  if (cyc !== e.cyc || sw !== e.val || sw_rise !== e.rise || sw_fall !== e.fall) begin
                     errors++;
                     $display("FAIL edge_update cyc=%0d sw=%h rise=%b fall=%b required cyc=%0d sw=%h rise=%b fall=%b",
                              cyc, sw, sw_rise, sw_fall, e.cyc, e.val, e.rise, e.fall);
                  end
               end
            end else begin
               checks++;
               if (sw_rise !== 4'h0 || sw_fall !== 4'h0) begin
                  errors++;
                  $display("FAIL edge_idle cyc=%0d rise=%b fall=%b required 0 0", cyc, sw_rise, sw_fall);
               end
            end
         end
         checks++;
         if (sbq.size() != 0 || sw !== pat[p]) begin
            errors++;
            $display("FAIL edge_final pending=%0d sw=%h required pending=0 sw=%h", sbq.size(), sw, pat[p]);
            sbq.delete();
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid_count();
      test_glitch();
      test_bounce();
      test_simultaneous();
`ifdef SW_DEBOUNCE_EDGE_EN
      test_edges();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Front-end conditioning stage for the board slide switches. It sits directly upstream of the 4-bit switch decoder and drives that decoder's sw input.
- Each raw asynchronous switch line is synchronized into clk, then debounced with a per-bit stability counter.
- The block presents a clean, glitch-free registered switch vector plus a change strobe.

Parameters:
- WIDTH, 4, number of switch lines (decoder input width).
- STABLE_CYCLES, 100000, consecutive stable clk cycles required before a new level is accepted (1 ms at 100 MHz); legal range >= 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw_raw  input  WIDTH  raw switch pins; asynchronous to clk, may bounce.
- sw  output  WIDTH  debounced switch levels; connects to the decoder sw input.
- sw_changed  output  1  one-cycle strobe: at least one sw bit changed this cycle.

Behaviour:
- Reset: asserting rst immediately clears all flops with no clock edge: sync stages, counters, sw, sw_changed (and edge pulses) go to 0. Release is synchronous in effect; the first rising edge after deassertion is edge 1.
- Synchronizer: two flops per bit (s1 <= sw_raw; s2 <= s1). There is no logic between the stages. sw_sync = s2.
- Per-bit counter cnt[i] of width $clog2(STABLE_CYCLES+1), evaluated each rising edge:
  - if sw_sync[i] == sw[i]: cnt[i] <= 0.
  - else if cnt[i] == STABLE_CYCLES-1: sw[i] <= sw_sync[i]; cnt[i] <= 0.
  - else: cnt[i] <= cnt[i] + 1.
- The counter never wraps; it is cleared at terminal count or on any matching sample.
- Glitch rejection: any single cycle where sw_sync[i] equals sw[i] restarts the count, so shorter pulses are discarded.
- Latency: sw_raw is held steady from before edge k. sw[i] takes the new value at edge k+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges counting edge k as 1.
- Bits are fully independent. Several bits qualifying on the same edge update together.
- sw_changed: registered alongside sw, so it is high in exactly the cycle sw first shows new value(s). It is the OR over all bits and is deasserted next edge unless another bit updates. Simultaneous updates give one pulse.
- Reset mid-count: partial counts are discarded. After release, a level held on sw_raw is re-qualified from zero. If switches are up at release, sw rises from 0 with a sw_changed pulse after STABLE_CYCLES+2 edges.
- sw is purely registered; no combinational path from sw_raw to any output.

Optional Feature:
- Macro: SW_DEBOUNCE_EDGE_EN.
- Defined: adds output ports sw_rise (WIDTH) and sw_fall (WIDTH), both reset to 0.
  - sw_rise[i] is high for exactly the cycle sw[i] goes 0->1.
  - sw_fall[i] is high for exactly the cycle sw[i] goes 1->0.
  - Both are registered and coincident with sw_changed.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan (bench uses STABLE_CYCLES=4, WIDTH=4):
1. rst=1 with sw_raw=4'hF -> sw=4'h0, sw_changed=0. Release rst and hold 4'hF -> sw=4'hF on edge 6 after release; sw_changed=1 for that single cycle only.
2. Bounce on bit0: toggle every 2 clk for 20 cycles, then hold 1 -> sw[0] stays 0 throughout the bounce; sw[0]=1 exactly 6 edges after the final transition; one sw_changed pulse.
3. Glitch: sw=4'h0, bit2 high for 3 cycles then low -> sw remains 4'h0; sw_changed never asserts.
4. Simultaneous change: from settled 4'h0, sw_raw=4'hD held -> sw goes 4'h0 to 4'hD in one cycle; exactly one sw_changed pulse.
5. Reset mid-operation: sw settled 4'hF, sw_raw->4'h0 held 3 edges, then rst asserted between edges -> sw=4'h0 and sw_changed=0 before any further edge. After release with sw_raw=4'h0, no sw_changed pulse.
6. With SW_DEBOUNCE_EDGE_EN: bit1 0->1 settles -> sw_rise=4'b0010 for one cycle, sw_fall=0. Later 1->0 -> sw_fall=4'b0010 for one cycle, sw_rise=0.
